// File: rtl/rib_bus_arbiter.sv
// rtl/rib_bus_arbiter.sv - three-master system bus arbiter with slave timeout
//
// Purpose:
//   Shares one system bus between NM masters (0 = JTAG debug, 1 = UART debug
//   loader, NM-1 = core). One master is granted per transaction; the grant is
//   held until the slave acks or the timeout counter expires. The core
//   pipeline is stalled through hold_core while it is waiting for the bus.
//
// Build option:
//   ARB_ROUND_ROBIN_EN - when defined, arbitration in IDLE is round-robin
//                        starting after the last granted master; otherwise
//                        fixed priority with master 0 highest.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   m_req      per-master request, held until its m_ack
//   m_we       per-master write enable
//   m_addr     packed per-master address, master i at [i*AW +: AW]
//   m_wdata    packed per-master write data, master i at [i*DW +: DW]
//   m_gnt      one-hot grant
//   m_ack      one-cycle completion pulse to the granted master
//   m_err      high with m_ack when the transaction timed out
//   m_rdata    read data, valid while m_ack is high
//   s_req      slave request
//   s_we       slave write enable
//   s_addr     slave address
//   s_wdata    slave write data
//   s_ack      slave completion, single cycle
//   s_rdata    slave read data, valid with s_ack
//   hold_core  stall to the core pipeline

`timescale 1ns/1ps

module rib_bus_arbiter #(
  parameter int NM      = 3,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NM-1:0]    m_req,
  input  logic [NM-1:0]    m_we,
  input  logic [NM*AW-1:0] m_addr,
  input  logic [NM*DW-1:0] m_wdata,
  output logic [NM-1:0]    m_gnt,
  output logic [NM-1:0]    m_ack,
  output logic             m_err,
  output logic [DW-1:0]    m_rdata,
  output logic             s_req,
  output logic             s_we,
  output logic [AW-1:0]    s_addr,
  output logic [DW-1:0]    s_wdata,
  input  logic             s_ack,
  input  logic [DW-1:0]    s_rdata,
  output logic             hold_core
);

  // The counter holds (BUSY cycles - 1), so the last BUSY cycle is the one
  // where it equals TIMEOUT-1.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);
  localparam int         CORE     = NM - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e        state_q;
  logic [NM-1:0] gnt_q;
  logic [NM-1:0] ack_q;
  logic          err_q;
  logic [DW-1:0] rdata_q;
  logic          s_req_q;
  logic          s_we_q;
  logic [AW-1:0] s_addr_q;
  logic [DW-1:0] s_wdata_q;
  logic [7:0]    cnt_q;

  logic [NM-1:0] gnt_d;
  logic          s_we_d;
  logic [AW-1:0] s_addr_d;
  logic [DW-1:0] s_wdata_d;

  // Isolate the lowest set bit: two's complement trick.
  function automatic logic [NM-1:0] lowest_set(input logic [NM-1:0] v);
    return v & (~v + NM'(1));
  endfunction

`ifdef ARB_ROUND_ROBIN_EN
  // Last-grant pointer kept one-hot; reset value points at master 0.
  logic [NM-1:0] last_q;
  logic [NM-1:0] above_last;
  logic [NM-1:0] req_above;

  // Bits strictly above the last grant; when the last grant is the top bit
  // the shift drops out and the mask becomes empty, forcing a wrap to 0.
  assign above_last = ~((last_q << 1) - NM'(1));
  assign req_above  = m_req & above_last;
  assign gnt_d      = (req_above != '0) ? lowest_set(req_above) : lowest_set(m_req);
`else
  assign gnt_d = lowest_set(m_req);
`endif

  // AND-OR mux of the winner's request fields, built as a chain so each
  // stage selects with a constant index.
  logic [AW-1:0] addr_chain  [NM+1];
  logic [DW-1:0] wdata_chain [NM+1];

  assign addr_chain[0]  = '0;
  assign wdata_chain[0] = '0;

  for (genvar i = 0; i < NM; i++) begin : g_mux
    assign addr_chain[i+1]  = addr_chain[i]  | (m_addr[i*AW +: AW]  & {AW{gnt_d[i]}});
    assign wdata_chain[i+1] = wdata_chain[i] | (m_wdata[i*DW +: DW] & {DW{gnt_d[i]}});
  end

  assign s_addr_d  = addr_chain[NM];
  assign s_wdata_d = wdata_chain[NM];
  assign s_we_d    = |(m_we & gnt_d);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      ack_q     <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      s_req_q   <= 1'b0;
      s_we_q    <= 1'b0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      cnt_q     <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q    <= NM'(1);
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (m_req != '0) begin
            gnt_q     <= gnt_d;
            s_req_q   <= 1'b1;
            s_we_q    <= s_we_d;
            s_addr_q  <= s_addr_d;
            s_wdata_q <= s_wdata_d;
            cnt_q     <= '0;
            state_q   <= BUSY;
`ifdef ARB_ROUND_ROBIN_EN
            last_q    <= gnt_d;
`endif
          end
        end

        BUSY: begin
          // An ack on the final counted cycle still completes normally.
          if (s_ack) begin
            rdata_q <= s_rdata;
            ack_q   <= gnt_q;
            err_q   <= 1'b0;
            s_req_q <= 1'b0;
            state_q <= DONE;
          end else if (cnt_q == CNT_LAST) begin
            rdata_q <= '0;
            ack_q   <= gnt_q;
            err_q   <= 1'b1;
            s_req_q <= 1'b0;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end

        DONE: begin
          gnt_q   <= '0;
          ack_q   <= '0;
          err_q   <= 1'b0;
          cnt_q   <= '0;
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign m_gnt   = gnt_q;
  assign m_ack   = ack_q;
  assign m_err   = err_q;
  assign m_rdata = rdata_q;
  assign s_req   = s_req_q;
  assign s_we    = s_we_q;
  assign s_addr  = s_addr_q;
  assign s_wdata = s_wdata_q;

  // The core stays stalled until the very cycle its own slave ack arrives.
  assign hold_core = m_req[CORE] & ~((state_q == BUSY) & gnt_q[CORE] & s_ack);

endmodule

// File: tb/tb_rib_bus_arbiter.sv
// tb/tb_rib_bus_arbiter.sv - self-checking bench for rib_bus_arbiter

`timescale 1ns/1ps

module tb_rib_bus_arbiter;

  localparam int NM      = 3;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TIMEOUT = 255;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    m_req;
  logic [2:0]    m_we;
  logic [95:0]   m_addr;
  logic [95:0]   m_wdata;
  logic [2:0]    m_gnt;
  logic [2:0]    m_ack;
  logic          m_err;
  logic [31:0]   m_rdata;
  logic          s_req;
  logic          s_we;
  logic [31:0]   s_addr;
  logic [31:0]   s_wdata;
  logic          s_ack;
  logic [31:0]   s_rdata;
  logic          hold_core;

  always #5 clk = ~clk;

  rib_bus_arbiter #(.NM(NM), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_gnt(m_gnt), .m_ack(m_ack), .m_err(m_err), .m_rdata(m_rdata),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_ack(s_ack), .s_rdata(s_rdata), .hold_core(hold_core)
  );

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Slave responder settings: ack on the lat-th BUSY cycle, 0 = never.
  int          lat;
  int          scnt;
  logic [31:0] rdata_val;
  bit          drop_en;

  logic [2:0]  sn_gnt   [0:299];
  logic [2:0]  sn_ack   [0:299];
  logic        sn_sreq  [0:299];
  logic        sn_hold  [0:299];
  logic        sn_err   [0:299];
  logic        sn_we    [0:299];
  logic [31:0] sn_rdata [0:299];
  logic [31:0] sn_addr  [0:299];

  // Transaction-level reference: which master owns the bus, how many
  // BUSY cycles have elapsed, and what the completion looked like.
  logic        x_busy, x_done, x_err, x_we;
  int          x_n, x_own, x_last, nxt;
  logic [31:0] x_addr, x_wdata, x_rdata;

  function automatic int pick(input logic [2:0] req, input int last);
`ifdef ARB_ROUND_ROBIN_EN
    int j;
    for (int k = 1; k <= 3; k++) begin
      j = (last + k) % 3;
      if (((req >> j) & 3'b001) != 3'b000) return j;
    end
`else
    for (int k = 0; k < 3; k++) begin
      if (((req >> k) & 3'b001) != 3'b000) return k;
    end
`endif
    return 0;
  endfunction

  always_comb nxt = pick(m_req, x_last);

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_busy <= 1'b0; x_done <= 1'b0; x_err <= 1'b0; x_we <= 1'b0;
      x_n <= 0; x_own <= 0; x_last <= 0;
      x_addr <= '0; x_wdata <= '0; x_rdata <= '0;
    end else if (x_busy) begin
      if (s_ack) begin
        x_busy <= 1'b0; x_done <= 1'b1; x_err <= 1'b0; x_rdata <= s_rdata;
      end else if (x_n == TIMEOUT) begin
        x_busy <= 1'b0; x_done <= 1'b1; x_err <= 1'b1; x_rdata <= '0;
      end else begin
        x_n <= x_n + 1;
      end
    end else if (x_done) begin
      x_done <= 1'b0;
      x_err  <= 1'b0;
    end else if (m_req != 3'b000) begin
      x_busy  <= 1'b1;
      x_n     <= 1;
      x_own   <= nxt;
      x_last  <= nxt;
      x_we    <= ((m_we >> nxt) & 3'b001) != 3'b000;
      x_addr  <= 32'(m_addr >> (32 * nxt));
      x_wdata <= 32'(m_wdata >> (32 * nxt));
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic compare();
    logic [2:0] oh;
    logic       eh;
    oh = (x_busy || x_done) ? (3'b001 << x_own) : 3'b000;
    eh = m_req[2] & ~(x_busy && (x_own == 2) && s_ack);
    chk("m_gnt",     32'(m_gnt),     32'(oh));
    chk("m_ack",     32'(m_ack),     x_done ? 32'(oh) : 32'h0);
    chk("m_err",     32'(m_err),     32'(x_done & x_err));
    chk("s_req",     32'(s_req),     32'(x_busy));
    chk("hold_core", 32'(hold_core), 32'(eh));
    if (x_busy) begin
      chk("s_we",    32'(s_we), 32'(x_we));
      chk("s_addr",  s_addr,    x_addr);
      chk("s_wdata", s_wdata,   x_wdata);
    end
    if (x_done) chk("m_rdata", m_rdata, x_rdata);
  endtask

  task automatic zeros_check(input string tag);
    chk({tag, "_gnt"},   32'(m_gnt),     32'h0);
    chk({tag, "_ack"},   32'(m_ack),     32'h0);
    chk({tag, "_err"},   32'(m_err),     32'h0);
    chk({tag, "_rdata"}, m_rdata,        32'h0);
    chk({tag, "_sreq"},  32'(s_req),     32'h0);
    chk({tag, "_swe"},   32'(s_we),      32'h0);
    chk({tag, "_saddr"}, s_addr,         32'h0);
    chk({tag, "_swdat"}, s_wdata,        32'h0);
    chk({tag, "_hold"},  32'(hold_core), 32'h0);
  endtask

  // One clock: masters drop on their ack, the slave answers on cycle lat.
  task automatic step();
    @(posedge clk);
    #1;
    if (drop_en) m_req = m_req & ~m_ack;
    if (!s_req) begin
      scnt    = 0;
      s_ack   = 1'b0;
      s_rdata = '0;
    end else begin
      scnt++;
      s_ack   = (lat != 0) && (scnt == lat);
      s_rdata = s_ack ? rdata_val : 32'h0;
    end
    #1;
  endtask

  task automatic run(input int from, input int to);
    for (int k = from; k <= to; k++) begin
      step();
      sn_gnt[k]   = m_gnt;
      sn_ack[k]   = m_ack;
      sn_sreq[k]  = s_req;
      sn_hold[k]  = hold_core;
      sn_err[k]   = m_err;
      sn_we[k]    = s_we;
      sn_rdata[k] = m_rdata;
      sn_addr[k]  = s_addr;
    end
  endtask

  task automatic master(input int i, input logic we, input logic [31:0] a, input logic [31:0] d);
    m_req[i]            = 1'b1;
    m_we[i]             = we;
    m_addr[i*32 +: 32]  = a;
    m_wdata[i*32 +: 32] = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; m_req = '0; m_we = '0; m_addr = '0; m_wdata = '0;
    s_ack = 1'b0; s_rdata = '0; lat = 0; scnt = 0; rdata_val = '0; drop_en = 1'b1;
    #3;
    zeros_check("reset");
    step(); step();
    rst = 1'b1;
    fork
      forever begin
        @(negedge clk);
        compare();
      end
    join_none
    step();

    // Single core read, slave acks on the third BUSY cycle.
    lat = 3; rdata_val = 32'hDEAD_BEEF;
    master(2, 1'b0, 32'h1000_0004, 32'h0);
    run(1, 6);
    chk("t1_sreq_lat1", 32'(sn_sreq[1]), 32'h1);
    chk("t1_gnt",       32'(sn_gnt[1]),  32'h4);
    chk("t1_addr",      sn_addr[1],      32'h1000_0004);
    chk("t1_hold_wait", 32'(sn_hold[2]), 32'h1);
    chk("t1_hold_ack",  32'(sn_hold[3]), 32'h0);
    chk("t1_noack3",    32'(sn_ack[3]),  32'h0);
    chk("t1_ack",       32'(sn_ack[4]),  32'h4);
    chk("t1_rdata",     sn_rdata[4],     32'hDEAD_BEEF);
    chk("t1_err",       32'(sn_err[4]),  32'h0);

    // JTAG and core together: JTAG first, core after the DONE gap.
    lat = 2; rdata_val = 32'h0BAD_F00D;
    master(0, 1'b1, 32'h0000_0100, 32'h1111_1111);
    master(2, 1'b0, 32'h1000_0008, 32'h0);
    run(1, 9);
    chk("t2_gnt_jtag",  32'(sn_gnt[1]),  32'h1);
    chk("t2_we_jtag",   32'(sn_we[1]),   32'h1);
    chk("t2_ack_jtag",  32'(sn_ack[3]),  32'h1);
    chk("t2_gnt_gap",   32'(sn_gnt[4]),  32'h0);
    chk("t2_gnt_core",  32'(sn_gnt[5]),  32'h4);
    chk("t2_hold_4",    32'(sn_hold[4]), 32'h1);
    chk("t2_hold_5",    32'(sn_hold[5]), 32'h1);
    chk("t2_hold_ack",  32'(sn_hold[6]), 32'h0);
    chk("t2_ack_core",  32'(sn_ack[7]),  32'h4);

    // Slave never acks; UART drops its request mid-transaction.
    lat = 0;
    master(1, 1'b1, 32'h2000_0000, 32'h1234_5678);
    run(1, 10);
    m_req[1] = 1'b0;
    run(11, 258);
    chk("t3_sreq_255",  32'(sn_sreq[255]), 32'h1);
    chk("t3_noack_255", 32'(sn_ack[255]),  32'h0);
    chk("t3_ack",       32'(sn_ack[256]),  32'h2);
    chk("t3_err",       32'(sn_err[256]),  32'h1);
    chk("t3_rdata",     sn_rdata[256],     32'h0);
    chk("t3_sreq_drop", 32'(sn_sreq[256]), 32'h0);
    chk("t3_gnt_clr",   32'(sn_gnt[257]),  32'h0);

    // Ack exactly on the last BUSY cycle wins over the timeout.
    lat = 255; rdata_val = 32'hCAFE_F00D;
    master(2, 1'b0, 32'h1000_0010, 32'h0);
    run(1, 258);
    chk("t4_ack",   32'(sn_ack[256]), 32'h4);
    chk("t4_err",   32'(sn_err[256]), 32'h0);
    chk("t4_rdata", sn_rdata[256],    32'hCAFE_F00D);

    // Asynchronous reset in BUSY, then re-arbitration of the pending request.
    lat = 0;
    master(0, 1'b1, 32'h3000_0000, 32'h5555_AAAA);
    run(1, 3);
    chk("t5_busy", 32'(sn_sreq[3]), 32'h1);
    #1;
    rst = 1'b0;
    #1;
    zeros_check("async");
    run(4, 4);
    rst = 1'b1; lat = 1;
    run(5, 9);
    chk("t5_sreq_rst", 32'(sn_sreq[4]), 32'h0);
    chk("t5_regnt",    32'(sn_gnt[5]),  32'h1);
    chk("t5_resreq",   32'(sn_sreq[5]), 32'h1);
    chk("t5_ack",      32'(sn_ack[6]),  32'h1);

    // All three requests held continuously.
    drop_en = 1'b0; lat = 1;
    master(0, 1'b0, 32'h0000_0200, 32'h0);
    master(1, 1'b0, 32'h2000_0200, 32'h0);
    master(2, 1'b0, 32'h1000_0200, 32'h0);
    run(1, 12);
`ifdef ARB_ROUND_ROBIN_EN
    chk("t6_gnt_a", 32'(sn_gnt[1]),  32'h2);
    chk("t6_gnt_b", 32'(sn_gnt[4]),  32'h4);
    chk("t6_gnt_c", 32'(sn_gnt[7]),  32'h1);
    chk("t6_gnt_d", 32'(sn_gnt[10]), 32'h2);
`else
    chk("t6_gnt_a", 32'(sn_gnt[1]),  32'h1);
    chk("t6_gnt_b", 32'(sn_gnt[4]),  32'h1);
    chk("t6_gnt_c", 32'(sn_gnt[7]),  32'h1);
    chk("t6_gnt_d", 32'(sn_gnt[10]), 32'h1);
`endif
    m_req = '0; drop_en = 1'b1;
    step(); step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
